// File: rtl/reg_file_sb.sv
// Register file with write-through bypass and a per-register busy scoreboard.
// Register 0 is hardwired to zero and can never be marked busy. The hazard
// output is advisory; the issuing controller is expected to honour it.
module reg_file_sb #(
   parameter int XLEN = 64,
   parameter int AW   = 5
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            we,
   input  logic [AW-1:0]   rw,
   input  logic [XLEN-1:0] din,
   input  logic [AW-1:0]   ra,
   input  logic [AW-1:0]   rb,
   output logic [XLEN-1:0] douta,
   output logic [XLEN-1:0] doutb,
   input  logic            use_a,
   input  logic            use_b,
   input  logic            issue_valid,
   input  logic [AW-1:0]   issue_rd,
   output logic            busy_a,
   output logic            busy_b,
   output logic            hazard,
   output logic [AW:0]     pend_cnt
);

   localparam int          NREG = 2 ** AW;
   localparam logic [AW:0] ONE  = {{AW{1'b0}}, 1'b1};

   logic [XLEN-1:0] regs [NREG];
   logic [NREG-1:0] busy;
   logic [NREG-1:0] busy_nxt;
   logic            wr_en;
   logic            set_en;
   logic            cnt_inc;
   logic            cnt_dec;

   assign wr_en  = we && (rw != '0);
   assign set_en = issue_valid && (issue_rd != '0);

   // Storage update; reset clears every register.
   // NOTE: clearing the whole array on reset forces it into flops rather than a
   // RAM macro; that is accepted because every register must read 0 after reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else if (wr_en) begin
         // NOTE: sequential state uses non-blocking assignments so all flops
         // sample pre-edge values regardless of statement order.
         regs[rw] <= din;
      end
   end

   // Read ports: register 0 forces zero, a same-cycle writeback is forwarded.
   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is
      // inferred on any path through the block.
      douta = regs[ra];
      doutb = regs[rb];
      if (wr_en && (rw == ra)) douta = din;
      if (wr_en && (rw == rb)) doutb = din;
      if (ra == '0) douta = '0;
      if (rb == '0) doutb = '0;
   end

   // Next busy vector: clear on writeback first, then set, so a same-register
   // set wins over its clear (the new producer is still outstanding).
   always_comb begin
      busy_nxt = busy;
      if (wr_en)  busy_nxt[rw]       = 1'b0;
      if (set_en) busy_nxt[issue_rd] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   // Count changes only when a busy bit actually flips.
   assign cnt_inc = set_en && !busy[issue_rd];
   assign cnt_dec = wr_en && busy[rw] && !(set_en && (issue_rd == rw));

   // Scoreboard state and pending counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         busy     <= '0;
         pend_cnt <= '0;
      end else begin
         busy <= busy_nxt;
         if (cnt_inc && !cnt_dec)      pend_cnt <= pend_cnt + ONE;
         else if (cnt_dec && !cnt_inc) pend_cnt <= pend_cnt - ONE;
      end
   end

   // Dependency status; a same-cycle writeback releases the dependency.
   always_comb begin
      busy_a = busy[ra] && !(we && (rw == ra));
      busy_b = busy[rb] && !(we && (rw == rb));
      hazard = (use_a && busy_a) || (use_b && busy_b) ||
               (set_en && busy[issue_rd] && !(we && (rw == issue_rd)));
   end

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 Parameter XLEN, default 64: data width of each register, in bits.
REQ-002 Parameter AW, default 5: register address width; register count NREG = 2**AW.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 we  input  1  write enable for the writeback port.
REQ-006 rw  input  AW  writeback destination register index.
REQ-007 din  input  XLEN  writeback data.
REQ-008 ra, rb  input  AW each  read port A and read port B register indices.
REQ-009 douta, doutb  output  XLEN each  read port A and read port B data.
REQ-010 use_a, use_b  input  1 each  the current instruction actually consumes ra / rb.
REQ-011 issue_valid  input  1  the current instruction issues this cycle and will later write issue_rd.
REQ-012 issue_rd  input  AW  destination register of the issuing instruction.
REQ-013 busy_a, busy_b  output  1 each  ra / rb has an outstanding, not-yet-written result.
REQ-014 hazard  output  1  the current instruction must stall (RAW or WAW).
REQ-015 pend_cnt  output  AW+1  number of registers currently marked busy.

Function
REQ-016 Storage: NREG registers of XLEN bits; register 0 reads as zero and is never written, whatever we/rw/din hold.
REQ-017 Write: on the clk edge with we=1 and rw!=0, reg[rw] <= din; with we=0 or rw=0, storage is unchanged.
REQ-018 Read: douta/doutb are combinational (zero-cycle latency); douta = reg[ra], doutb = reg[rb].
REQ-019 Bypass: if we=1, rw!=0 and rw==ra, douta = din in the same cycle (write-through); doutb likewise for rb.
REQ-020 Bypass on register 0: ra=0 or rb=0 returns 0 even if rw=0 and we=1.
REQ-021 Scoreboard: one busy bit per register; busy[0] is constant 0.
REQ-022 Set: on the clk edge with issue_valid=1 and issue_rd!=0, busy[issue_rd] <= 1.
REQ-023 Clear: on the clk edge with we=1 and rw!=0, busy[rw] <= 0.
REQ-024 Set and clear on the same register in the same cycle: set wins, so busy stays 1 (the new producer is outstanding).
REQ-025 Set and clear on different registers in the same cycle: both take effect.
REQ-026 busy_a = busy[ra] AND NOT (we=1 AND rw==ra); busy_b is defined the same way for rb, so a same-cycle writeback releases the dependency.
REQ-027 hazard = (use_a AND busy_a) OR (use_b AND busy_b) OR (issue_valid AND issue_rd!=0 AND busy[issue_rd] AND NOT (we AND rw==issue_rd)).
REQ-028 hazard is advisory: the block does not gate issue_valid internally; the upstream controller holds issue_valid=0 while hazard=1.
REQ-029 pend_cnt equals the population count of busy[] after each edge, in the range 0..NREG-1; it is updated +1, -1, or 0 per cycle in step with REQ-022..025 and never wraps.
REQ-030 Re-issue to an already busy register without a clear leaves busy at 1 and pend_cnt unchanged.
REQ-031 A writeback to a register that is not busy updates storage and leaves busy and pend_cnt unchanged.

Reset
REQ-032 While reset=1 at a clk edge, all registers are cleared to 0, busy[] is cleared to 0, and pend_cnt is cleared to 0; reset overrides we and issue_valid in that cycle.
REQ-033 After reset: douta=doutb=0, busy_a=busy_b=0, hazard=0, pend_cnt=0.
REQ-034 Reset asserted mid-operation discards all pending scoreboard entries; a writeback arriving after reset still writes storage and has no scoreboard effect.

Verification
REQ-035 Reset, then write x5=0x1234 and x0=0xFFFF; read ra=5, rb=0 -> douta=0x1234, doutb=0.
REQ-036 Bypass: we=1, rw=7, din=0xAA, ra=7 in the same cycle -> douta=0xAA before the edge; after the edge, reg[7]=0xAA.
REQ-037 RAW: issue rd=3; next cycle ra=3, use_a=1 -> busy_a=1, hazard=1, pend_cnt=1; a writeback to x3 with ra=3 in the same cycle -> busy_a=0, hazard=0; after the edge, pend_cnt=0.
REQ-038 Same-cycle set and clear on x4 (issue_rd=4, we=1, rw=4, x4 already busy) -> busy[4] stays 1, pend_cnt unchanged.
REQ-039 Issue x1..x31 on consecutive cycles -> pend_cnt=31 and issue_rd=0 sets nothing; assert reset -> pend_cnt=0 and every register reads 0.
REQ-040 Parameter sweep at XLEN=32, AW=4 -> bench repeats REQ-035..038 with pend_cnt saturating at 15.
